// File: rtl/sdram_word_responder_if.sv
// Word-address memory bus between an initiator (master) and sdram_word_responder (slave).
interface sdram_word_responder_if;
  logic [19:1] m_addr;
  logic [15:0] m_data_out;
  logic [15:0] m_data_in;
  logic        m_access;
  logic        m_ack;
  logic        m_wr_en;
  logic [1:0]  m_bytesel;

  modport master (
    output m_addr, m_data_out, m_access, m_wr_en, m_bytesel,
    input  m_data_in, m_ack
  );

  modport slave (
    input  m_addr, m_data_out, m_access, m_wr_en, m_bytesel,
    output m_data_in, m_ack
  );
endinterface

// File: rtl/sdram_word_responder.sv
// Word RAM behind the m_* bus with fixed max(LATENCY,1)-edge access latency; one request at a time,
// the initiator holds m_access until the one-cycle m_ack, and completed writes pulse inval_valid.
module sdram_word_responder #(
  parameter int unsigned DEPTH     = 524288,
  parameter int unsigned LATENCY   = 2,
  parameter string       INIT_FILE = ""
) (
  input  logic                    clk,
  input  logic                    reset,
  sdram_word_responder_if.slave   m,
  output logic                    inval_valid,
  output logic [19:1]             inval_addr,
  output logic                    proto_err,
  output logic [15:0]             wr_count,
  output logic [15:0]             rd_count
);
  localparam int unsigned AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned LAT = (LATENCY == 0) ? 1 : LATENCY;
  localparam int unsigned CW  = $clog2(LAT + 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t         state, state_nxt;
  logic [CW-1:0]  cnt;
  logic           capture, complete;
  logic [19:1]    cap_addr;
  logic [15:0]    cap_data;
  logic           cap_wr;
  logic [1:0]     cap_bsel;
  logic [AW-1:0]  idx;
  logic [15:0]    ram [DEPTH];

  assign idx = cap_addr[AW:1];

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    complete  = 1'b0;
    case (state)
      IDLE: begin
        if (m.m_access) begin
          capture   = 1'b1;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (cnt == CW'(1)) begin
          complete  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt         <= '0;
      cap_addr    <= '0;
      cap_data    <= '0;
      cap_wr      <= 1'b0;
      cap_bsel    <= '0;
      m.m_ack     <= 1'b0;
      m.m_data_in <= '0;
      inval_valid <= 1'b0;
      inval_addr  <= '0;
      proto_err   <= 1'b0;
      wr_count    <= '0;
      rd_count    <= '0;
    end else begin
      m.m_ack     <= complete;
      inval_valid <= complete & cap_wr & (|cap_bsel);
      if (capture) begin
        cap_addr <= m.m_addr;
        cap_data <= m.m_data_out;
        cap_wr   <= m.m_wr_en;
        cap_bsel <= m.m_bytesel;
        cnt      <= CW'(LAT);
      end else if (state == BUSY) begin
        cnt <= cnt - CW'(1);
      end
      // The initiator must hold the request stable while busy; completion still uses captured values.
      if (state == BUSY && (!m.m_access || m.m_addr != cap_addr ||
                            m.m_wr_en != cap_wr || m.m_bytesel != cap_bsel))
        proto_err <= 1'b1;
      if (complete) begin
        if (cap_wr) begin
          wr_count <= wr_count + 16'd1;
          if (|cap_bsel) inval_addr <= cap_addr;
        end else begin
          rd_count    <= rd_count + 16'd1;
          m.m_data_in <= ram[idx];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && complete && cap_wr) begin
      if (cap_bsel[0]) ram[idx][7:0]  <= cap_data[7:0];
      if (cap_bsel[1]) ram[idx][15:8] <= cap_data[15:8];
    end
  end
endmodule
